// File: rtl/conv_sched_pkg.sv
// Shared widths and FSM state encoding for the convolution window scheduler.
package conv_sched_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DIM_W_DEF  = 8;
  localparam int K_W_DEF    = 4;
  localparam int STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

endpackage

// File: rtl/conv_win_counter.sv
// Nested kx/ky/ox/oy window counters with an incrementally maintained tap address
// (line/window/row pointers, so no multiplier sits on the address path).
module conv_win_counter
  import conv_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF,
  parameter int K_W    = K_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_adv,
  input  logic [DIM_W-1:0]  i_img_w,
  input  logic [DIM_W-1:0]  i_img_h,
  input  logic [K_W-1:0]    i_k,
  input  logic [ADDR_W-1:0] i_base,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_win_last,
  output logic              o_job_last
);

  logic [K_W-1:0]    r_kx, r_ky;
  logic [DIM_W-1:0]  r_ox, r_oy;
  logic [ADDR_W-1:0] r_line_ptr, r_win_ptr, r_row_ptr, r_addr;

  logic [K_W-1:0]    w_k_max;
  logic [DIM_W-1:0]  w_ox_max, w_oy_max;
  logic [ADDR_W-1:0] w_stride, w_row_next, w_win_next, w_line_next;
  logic              w_kx_last, w_ky_last, w_ox_last, w_oy_last;

  assign w_k_max     = i_k - K_W'(1);
  assign w_ox_max    = i_img_w - DIM_W'(i_k);
  assign w_oy_max    = i_img_h - DIM_W'(i_k);
  assign w_stride    = ADDR_W'(i_img_w);
  assign w_row_next  = r_row_ptr + w_stride;
  assign w_win_next  = r_win_ptr + ADDR_W'(1);
  assign w_line_next = r_line_ptr + w_stride;

  assign w_kx_last = (r_kx == w_k_max);
  assign w_ky_last = (r_ky == w_k_max);
  assign w_ox_last = (r_ox == w_ox_max);
  assign w_oy_last = (r_oy == w_oy_max);

  assign o_addr     = r_addr;
  assign o_win_last = w_kx_last && w_ky_last;
  assign o_job_last = w_kx_last && w_ky_last && w_ox_last && w_oy_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_kx       <= '0;
      r_ky       <= '0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_line_ptr <= '0;
      r_win_ptr  <= '0;
      r_row_ptr  <= '0;
      r_addr     <= '0;
    end else if (i_load) begin
      r_kx       <= '0;
      r_ky       <= '0;
      r_ox       <= '0;
      r_oy       <= '0;
      r_line_ptr <= i_base;
      r_win_ptr  <= i_base;
      r_row_ptr  <= i_base;
      r_addr     <= i_base;
    end else if (i_adv) begin
      if (!w_kx_last) begin
        r_kx   <= r_kx + K_W'(1);
        r_addr <= r_addr + ADDR_W'(1);
      end else if (!w_ky_last) begin
        r_kx      <= '0;
        r_ky      <= r_ky + K_W'(1);
        r_row_ptr <= w_row_next;
        r_addr    <= w_row_next;
      end else if (!w_ox_last) begin
        r_kx      <= '0;
        r_ky      <= '0;
        r_ox      <= r_ox + DIM_W'(1);
        r_win_ptr <= w_win_next;
        r_row_ptr <= w_win_next;
        r_addr    <= w_win_next;
      end else if (!w_oy_last) begin
        // Next output row: the window restarts at the left edge one image row down.
        r_kx       <= '0;
        r_ky       <= '0;
        r_ox       <= '0;
        r_oy       <= r_oy + DIM_W'(1);
        r_line_ptr <= w_line_next;
        r_win_ptr  <= w_line_next;
        r_row_ptr  <= w_line_next;
        r_addr     <= w_line_next;
      end
    end
  end

endmodule

// File: rtl/conv_window_scheduler.sv
// Job FSM and valid/ready tap handshake for the K x K window address sequencer.
// Optional stall counter output enabled by defining CONV_SCHED_STALL_CNT_EN.
module conv_window_scheduler
  import conv_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF,
  parameter int K_W    = K_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [K_W-1:0]    k_size,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              win_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [2:0]        state
`ifdef CONV_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  state_t            r_state, w_state_next;
  logic [DIM_W-1:0]  r_img_w, r_img_h;
  logic [K_W-1:0]    r_k;
  logic [ADDR_W-1:0] r_base;
  logic              r_rd_valid;

  logic w_cfg_bad, w_hs, w_load, w_start_acc, w_win_last, w_job_last;

  assign w_cfg_bad = (r_k == '0) || (DIM_W'(r_k) > r_img_w) || (DIM_W'(r_k) > r_img_h);
  assign w_hs      = r_rd_valid && rd_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_start_acc  = 1'b0;
    cfg_err      = 1'b0;
    done         = 1'b0;
    busy         = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_acc  = 1'b1;
          w_state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_cfg_bad) begin
          cfg_err      = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_load       = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_hs && w_job_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_img_w <= '0;
      r_img_h <= '0;
      r_k     <= '0;
      r_base  <= '0;
    end else if (w_start_acc) begin
      r_img_w <= img_w;
      r_img_h <= img_h;
      r_k     <= k_size;
      r_base  <= base_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_rd_valid <= 1'b0;
    else if (w_load)             r_rd_valid <= 1'b1;
    else if (w_hs && w_job_last) r_rd_valid <= 1'b0;
  end

  conv_win_counter #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W),
    .K_W    (K_W)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_adv      (w_hs),
    .i_img_w    (r_img_w),
    .i_img_h    (r_img_h),
    .i_k        (r_k),
    .i_base     (r_base),
    .o_addr     (rd_addr),
    .o_win_last (w_win_last),
    .o_job_last (w_job_last)
  );

  // Counters park on the final tap between jobs, so the flag is gated by valid.
  assign win_last = r_rd_valid && w_win_last;
  assign rd_valid = r_rd_valid;
  assign state    = r_state;

`ifdef CONV_SCHED_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_stall_cnt <= '0;
    else if (w_start_acc)
      r_stall_cnt <= '0;
    else if (r_rd_valid && !rd_ready && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed self-checking bench for conv_window_scheduler (one task per scenario).
module tb_conv_window_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] img_w, img_h;
  logic [3:0] k_size;
  logic [7:0] base_addr;
  logic [7:0] rd_addr;
  logic       rd_valid, rd_ready, win_last, busy, done, cfg_err;
  logic [2:0] state;
`ifdef CONV_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] addr_q[$];
  logic       last_q[$];
  logic [7:0] stall_addr_q[$];
  logic [7:0] exp_addr_q[$];
  logic       exp_last_q[$];
  int   first_lat, done_cnt, done_cyc, last_hs_cyc, err_cnt, err_cyc, timeout;
  logic busy_c1;

  always #5 clk = ~clk;

  conv_window_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .img_w     (img_w),
    .img_h     (img_h),
    .k_size    (k_size),
    .base_addr (base_addr),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .win_last  (win_last),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .state     (state)
`ifdef CONV_SCHED_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference tap order: base + (oy+ky)*w + (ox+kx), modulo 256.
  task automatic build_exp(input int w, input int h, input int k, input int b);
    exp_addr_q.delete();
    exp_last_q.delete();
    for (int oy = 0; oy <= h - k; oy++)
      for (int ox = 0; ox <= w - k; ox++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            exp_addr_q.push_back(8'((b + (oy + ky) * w + ox + kx) % 256));
            exp_last_q.push_back((kx == k - 1) && (ky == k - 1));
          end
  endtask

  // Launches one job and records every accepted tap; compares nothing itself.
  task automatic run_job(input logic [7:0] w, input logic [7:0] h, input logic [3:0] k,
                         input logic [7:0] b, input int stall_at, input int stall_len,
                         input int start_at);
    int cyc, stalled;
    logic fin;
    addr_q.delete();
    last_q.delete();
    stall_addr_q.delete();
    first_lat = -1; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
    err_cnt = 0; err_cyc = -1; timeout = 0; stalled = 0; fin = 1'b0; busy_c1 = 1'b0;
    img_w = w; img_h = h; k_size = k; base_addr = b; rd_ready = 1'b1; start = 1'b1;
    cyc = 0;
    for (int n = 0; n < 3000 && !fin; n++) begin
      step();
      cyc++;
      start = (start_at >= 0 && rd_valid && addr_q.size() == start_at);
      if (cyc == 1) busy_c1 = busy;
      if (rd_valid && first_lat < 0) first_lat = cyc;
      if (cfg_err) begin err_cnt++; err_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (rd_valid && addr_q.size() == stall_at && stalled < stall_len) begin
        rd_ready = 1'b0;
        stalled++;
        stall_addr_q.push_back(rd_addr);
      end else begin
        rd_ready = 1'b1;
      end
      if (rd_valid && rd_ready) begin
        addr_q.push_back(rd_addr);
        last_q.push_back(win_last);
        last_hs_cyc = cyc;
      end
      if (cyc >= 2 && state == 3'd0) fin = 1'b1;
    end
    start = 1'b0;
    rd_ready = 1'b1;
    if (!fin) timeout = 1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; rd_ready = 1'b1;
    img_w = 8'd0; img_h = 8'd0; k_size = 4'd0; base_addr = 8'd0;
    step(); step();
    checks++;
    if ({rd_addr, rd_valid, win_last, busy, done, cfg_err, state} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got addr=%h v=%b wl=%b busy=%b done=%b err=%b st=%0d expected all 0",
               rd_addr, rd_valid, win_last, busy, done, cfg_err, state);
    end
    rst = 1'b1;
    step();
    checks++;
    if (state !== 3'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got st=%0d v=%b expected st=0 v=0", state, rd_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int n, mism;
    logic [31:0] got;
    run_job(8'd4, 8'd4, 4'd2, 8'h10, -1, 0, -1);
    build_exp(4, 4, 2, 16);
    n = addr_q.size();
    checks++;
    if (timeout != 0) begin
      errors++;
      $display("FAIL basic_timeout got %0d expected 0", timeout);
    end
    checks++;
    if (first_lat != 2) begin
      errors++;
      $display("FAIL basic_first_valid_latency got %0d expected 2", first_lat);
    end
    checks++;
    if (busy_c1 !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_after_start got %b expected 1", busy_c1);
    end
    checks++;
    if (n != 36) begin
      errors++;
      $display("FAIL basic_tap_count got %0d expected 36", n);
    end
    got = {addr_q[0], addr_q[1], addr_q[2], addr_q[3]};
    checks++;
    if (got !== 32'h10111415) begin
      errors++;
      $display("FAIL basic_first_window got %h expected 10111415", got);
    end
    checks++;
    if ({last_q[0], last_q[1], last_q[2], last_q[3]} !== 4'b0001) begin
      errors++;
      $display("FAIL basic_first_win_last got %b%b%b%b expected 0001",
               last_q[0], last_q[1], last_q[2], last_q[3]);
    end
    got = (n >= 4) ? {addr_q[n-4], addr_q[n-3], addr_q[n-2], addr_q[n-1]} : 32'hxxxxxxxx;
    checks++;
    if (got !== 32'h1A1B1E1F) begin
      errors++;
      $display("FAIL basic_last_window got %h expected 1a1b1e1f", got);
    end
    mism = 0;
    for (int i = 0; i < 36; i++)
      if (i >= n || addr_q[i] !== exp_addr_q[i] || last_q[i] !== exp_last_q[i]) mism++;
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL basic_sequence got %0d mismatched taps expected 0", mism);
    end
    checks++;
    if (last_hs_cyc != 37) begin
      errors++;
      $display("FAIL basic_no_bubbles got last tap cycle %0d expected 37", last_hs_cyc);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin
      errors++;
      $display("FAIL basic_done_pulse got cnt=%0d cyc=%0d expected cnt=1 cyc=%0d",
               done_cnt, done_cyc, last_hs_cyc + 1);
    end
    checks++;
    if (busy !== 1'b0 || state !== 3'd0 || err_cnt != 0) begin
      errors++;
      $display("FAIL basic_end_idle got busy=%b st=%0d errs=%0d expected 0 0 0", busy, state, err_cnt);
    end
    $display("test_basic done taps=%0d", n);
  endtask

  task automatic test_stall();
    int mism;
    run_job(8'd4, 8'd4, 4'd2, 8'h10, 2, 3, -1);
    build_exp(4, 4, 2, 16);
    checks++;
    if (stall_addr_q.size() != 3) begin
      errors++;
      $display("FAIL stall_cycles got %0d expected 3", stall_addr_q.size());
    end
    mism = 0;
    foreach (stall_addr_q[i]) if (stall_addr_q[i] !== 8'h14) mism++;
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL stall_addr_hold got %0d bad cycles expected 0", mism);
    end
    mism = 0;
    for (int i = 0; i < 36; i++)
      if (i >= addr_q.size() || addr_q[i] !== exp_addr_q[i] || last_q[i] !== exp_last_q[i]) mism++;
    checks++;
    if (mism != 0 || addr_q.size() != 36) begin
      errors++;
      $display("FAIL stall_sequence got %0d mismatches, %0d taps expected 0, 36", mism, addr_q.size());
    end
    checks++;
    if (last_hs_cyc != 40 || done_cnt != 1) begin
      errors++;
      $display("FAIL stall_timing got last=%0d done=%0d expected 40 1", last_hs_cyc, done_cnt);
    end
`ifdef CONV_SCHED_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd3) begin
      errors++;
      $display("FAIL stall_cnt got %0d expected 3", stall_cnt);
    end
`endif
    $display("test_stall done");
  endtask

  task automatic test_cfg_err();
    run_job(8'd4, 8'd4, 4'd5, 8'h10, -1, 0, -1);
    checks++;
    if (err_cnt != 1 || err_cyc != 1) begin
      errors++;
      $display("FAIL cfgerr_k5_pulse got cnt=%0d cyc=%0d expected 1 1", err_cnt, err_cyc);
    end
    checks++;
    if (first_lat != -1 || done_cnt != 0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL cfgerr_k5_quiet got lat=%0d done=%0d taps=%0d expected -1 0 0",
               first_lat, done_cnt, addr_q.size());
    end
    checks++;
    if (state !== 3'd0 || busy !== 1'b0 || timeout != 0) begin
      errors++;
      $display("FAIL cfgerr_k5_idle got st=%0d busy=%b to=%0d expected 0 0 0", state, busy, timeout);
    end
    run_job(8'd4, 8'd4, 4'd0, 8'h10, -1, 0, -1);
    checks++;
    if (err_cnt != 1 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL cfgerr_k0 got errs=%0d taps=%0d expected 1 0", err_cnt, addr_q.size());
    end
    run_job(8'd8, 8'd4, 4'd5, 8'h00, -1, 0, -1);
    checks++;
    if (err_cnt != 1 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL cfgerr_k_gt_h got errs=%0d taps=%0d expected 1 0", err_cnt, addr_q.size());
    end
    $display("test_cfg_err done");
  endtask

  task automatic test_wrap();
    logic [7:0] exp_w[9];
    int mism, nlast;
    exp_w = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_job(8'd3, 8'd3, 4'd3, 8'hFE, -1, 0, -1);
    mism = 0;
    nlast = 0;
    for (int i = 0; i < 9; i++) if (i >= addr_q.size() || addr_q[i] !== exp_w[i]) mism++;
    foreach (last_q[i]) if (last_q[i] === 1'b1) nlast++;
    checks++;
    if (mism != 0 || addr_q.size() != 9) begin
      errors++;
      $display("FAIL wrap_sequence got %0d mismatches, %0d taps expected 0, 9", mism, addr_q.size());
    end
    checks++;
    if (nlast != 1 || last_q[8] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_win_last got %0d flags, last=%b expected 1, 1", nlast, last_q[8]);
    end
    checks++;
    if (done_cnt != 1 || err_cnt != 0) begin
      errors++;
      $display("FAIL wrap_done got done=%0d err=%0d expected 1 0", done_cnt, err_cnt);
    end
    $display("test_wrap done");
  endtask

  task automatic test_nonsquare();
    int mism;
    run_job(8'd5, 8'd3, 4'd2, 8'h40, -1, 0, -1);
    build_exp(5, 3, 2, 64);
    mism = 0;
    for (int i = 0; i < 32; i++)
      if (i >= addr_q.size() || addr_q[i] !== exp_addr_q[i] || last_q[i] !== exp_last_q[i]) mism++;
    checks++;
    if (mism != 0 || addr_q.size() != 32) begin
      errors++;
      $display("FAIL nonsquare_sequence got %0d mismatches, %0d taps expected 0, 32", mism, addr_q.size());
    end
    $display("test_nonsquare done");
  endtask

  task automatic test_start_in_issue();
    int mism;
    run_job(8'd4, 8'd4, 4'd2, 8'h10, -1, 0, 5);
    build_exp(4, 4, 2, 16);
    mism = 0;
    for (int i = 0; i < 36; i++)
      if (i >= addr_q.size() || addr_q[i] !== exp_addr_q[i]) mism++;
    checks++;
    if (mism != 0 || addr_q.size() != 36 || done_cnt != 1) begin
      errors++;
      $display("FAIL start_in_issue got %0d mismatches, %0d taps, done=%0d expected 0, 36, 1",
               mism, addr_q.size(), done_cnt);
    end
    $display("test_start_in_issue done");
  endtask

  task automatic test_reset_mid();
    img_w = 8'd4; img_h = 8'd4; k_size = 4'd2; base_addr = 8'h10; rd_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
    checks++;
    if (rd_valid !== 1'b1 || rd_addr !== 8'h16) begin
      errors++;
      $display("FAIL rstmid_tap10 got v=%b addr=%h expected 1 16", rd_valid, rd_addr);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({rd_addr, rd_valid, win_last, busy, done, cfg_err, state} !== 16'h0) begin
      errors++;
      $display("FAIL rstmid_async got addr=%h v=%b wl=%b busy=%b st=%0d expected all 0",
               rd_addr, rd_valid, win_last, busy, state);
    end
    step(); step();
    rst = 1'b1;
    step();
    checks++;
    if (rd_valid !== 1'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_after_release got v=%b st=%0d expected 0 0", rd_valid, state);
    end
    run_job(8'd4, 8'd4, 4'd2, 8'h10, -1, 0, -1);
    checks++;
    if (addr_q[0] !== 8'h10 || addr_q.size() != 36) begin
      errors++;
      $display("FAIL rstmid_restart got first=%h taps=%0d expected 10 36", addr_q[0], addr_q.size());
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_cfg_err();
    test_wrap();
    test_nonsquare();
    test_start_in_issue();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_scheduler.md
Name: conv_window_scheduler

Overview:
- Sequences read addresses for a K×K convolution window sliding over an image stored row-major in the accelerator's memory.
- Sits between the top-level control (start/config) and the memory read port / MAC datapath.
- Emits one tap address per accepted valid/ready handshake, window by window, and flags the last tap of each window.
- Stride fixed at 1, no padding.

Parameters:
- ADDR_W, 8, memory address width; all address arithmetic is modulo 2^ADDR_W.
- DIM_W, 8, width of image width/height config.
- K_W, 4, width of kernel size config.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- img_w  in  DIM_W  image width in pixels; latched on start.
- img_h  in  DIM_W  image height in pixels; latched on start.
- k_size  in  K_W  kernel side K; latched on start.
- base_addr  in  ADDR_W  address of pixel (0,0); latched on start.
- rd_addr  out  ADDR_W  tap address, registered.
- rd_valid  out  1  rd_addr is valid.
- rd_ready  in  1  consumer accepts the tap this cycle.
- win_last  out  1  qualifies rd_valid; current tap is the last of its window (ky=K-1, kx=K-1).
- busy  out  1  high from CHECK through DONE.
- done  out  1  one-cycle pulse at job completion.
- cfg_err  out  1  one-cycle pulse when the config is rejected.
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; rd_addr=0, rd_valid=0, win_last=0, busy=0, done=0, cfg_err=0; all counters=0. Applies immediately mid-job; no further taps are issued.
- States (encoding): IDLE=0, CHECK=1, ISSUE=2, DONE=3.
- IDLE:
  - start=1 latches the config and goes to CHECK.
  - start is ignored in every other state.
- CHECK (1 cycle):
  - Error if K==0, K>img_w or K>img_h: pulse cfg_err for 1 cycle and return to IDLE. done does not pulse.
  - Otherwise: load the first tap, set rd_valid=1, go to ISSUE.
  - First rd_valid is therefore asserted 2 cycles after the start edge.
- ISSUE:
  - rd_addr = base + (oy+ky)*img_w + (ox+kx), truncated to ADDR_W.
  - Loop order, innermost first: kx 0..K-1, ky 0..K-1, ox 0..img_w-K, oy 0..img_h-K.
  - Counters advance only on rd_valid && rd_ready.
  - While rd_valid && !rd_ready: rd_addr and win_last hold stable.
  - rd_valid stays high between consecutive taps (no bubbles).
  - Address computation uses incremental row pointers; no combinational multiplier on the rd_addr path.
  - Handshake on the final tap (last tap of the last window): rd_valid drops the next cycle and the FSM goes to DONE.
- DONE: done=1 for exactly 1 cycle, busy=1, then IDLE.
- busy:
  - Low in IDLE.
  - Asserted the cycle after start is accepted.
  - Deasserts in the cycle after done.
- Tap count: (img_h-K+1)*(img_w-K+1)*K*K handshakes per job.
- Wrap-around: addresses beyond 2^ADDR_W-1 wrap silently; not an error.
- start arriving in the same cycle as the DONE→IDLE transition is ignored; start is accepted only while state==IDLE.

Optional Feature:
- Macro: CONV_SCHED_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt[15:0].
  - Counts cycles with rd_valid && !rd_ready.
  - Cleared to 0 when start is accepted; saturates at 0xFFFF.
  - Holds its value after done; reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package conv_sched_pkg holds:
  - State enum localparams (IDLE/CHECK/ISSUE/DONE, 3-bit).
  - Default widths ADDR_W/DIM_W/K_W.
- One natural sub-module, conv_win_counter: nested kx/ky/ox/oy counters with wrap and "last" flags, plus the incremental row-pointer address.
- The FSM and handshake stay in the top module.

Test Plan:
- 4×4 image, K=2, base=0x10, rd_ready=1: 36 taps total.
  - First window addresses 0x10, 0x11, 0x14, 0x15, with win_last on 0x15.
  - Last window addresses 0x1A, 0x1B, 0x1E, 0x1F.
  - done pulses 1 cycle after the 0x1F handshake.
  - First rd_valid 2 cycles after start.
- Same job with rd_ready held low for 3 cycles at tap 2 (0x14): rd_addr stays 0x14 and rd_valid stays 1 for those cycles; sequence otherwise unchanged; with CONV_SCHED_STALL_CNT_EN, stall_cnt=3 at done.
- K=5 on a 4×4 image: cfg_err pulses 1 cycle after start; rd_valid never asserts; done stays 0; back in IDLE (state=0).
- K=3, 3×3 image, base=0xFE: single window of 9 taps 0xFE, 0xFF, 0x00, 0x01, 0x02, 0x03, 0x04, 0x05, 0x06 (wrap); win_last only on 0x06.
- Reset mid-job: drive rst=0 during tap 10 of the 4×4/K=2 job. All outputs go 0 immediately (asynchronously); a new start after release restarts from 0x10.
- start pulsed during ISSUE: ignored, tap sequence and tap count unchanged.
